// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared constants and fetch FSM encodings for the RV32I front end
package instruction_fetch_pkg;

  localparam logic [31:0] RV32_NOP         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [0:0] {
    FS_RUN   = 1'b0,
    FS_FLUSH = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_fifo.sv
// rtl/instruction_fetch_fifo.sv - synchronous FIFO holding {pc, instr} pairs for decode
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       clear,
  output logic [$clog2(DEPTH):0]     count,
  output logic [WIDTH-1:0]           head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !clear && !reset) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC owner, credit-limited imem issue and redirect flush for the fetch stage
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter int               FIFO_DEPTH = 2,
  parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             branchpcwe,
  input  logic [WIDTH-1:0] dnextpc,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_data,
  output logic             if_valid,
  input  logic             if_ready,
  output logic [WIDTH-1:0] if_pc,
  output logic [31:0]      if_instr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 2;
  localparam int DW = WIDTH + 32;
  localparam logic [CW-1:0] CREDITS = CW'(FIFO_DEPTH);

  fetch_state_t     state;
  fetch_state_t     state_n;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_n;
  logic [WIDTH-1:0] rsp_pc;
  logic [WIDTH-1:0] rsp_pc_n;
  logic [WIDTH-1:0] redirect_pc;
  logic [WIDTH-1:0] req_addr_n;
  logic             req_valid_n;
  logic             req_stale;
  logic             req_stale_n;
  logic [CW-1:0]    outstanding;
  logic [CW-1:0]    outstanding_n;
  logic [CW-1:0]    discard;
  logic [CW-1:0]    discard_n;
  logic [CW-1:0]    count_n;
  logic [AW:0]      fifo_count;
  logic [DW-1:0]    fifo_head;
  logic             fire;
  logic             push;
  logic             pop;
  logic             raise;

  assign fire        = imem_req_valid & imem_req_ready;
  assign redirect_pc = dnextpc & ~WIDTH'(3);
  assign push        = imem_rsp_valid & (discard == '0) & ~branchpcwe;
  assign pop         = if_valid & if_ready & ~branchpcwe;

  assign if_valid = (fifo_count != '0);
  assign if_pc    = if_valid ? fifo_head[DW-1:32] : '0;
  assign if_instr = if_valid ? fifo_head[31:0] : RV32_NOP;

  fetch_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({rsp_pc, imem_rsp_data}),
    .pop       (pop),
    .clear     (branchpcwe),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  always_comb begin
    pc_n          = pc;
    rsp_pc_n      = rsp_pc;
    req_stale_n   = req_stale;
    discard_n     = discard;
    state_n       = state;
    outstanding_n = outstanding + CW'(fire) - CW'(imem_rsp_valid);
    count_n       = CW'(fifo_count) + CW'(push) - CW'(pop);

    if (branchpcwe) begin
      // A request still waiting for ready belongs to the old path: it must
      // complete, be dropped, and not advance the new PC when it fires.
      pc_n        = redirect_pc;
      rsp_pc_n    = redirect_pc;
      req_stale_n = imem_req_valid & ~imem_req_ready;
      discard_n   = outstanding + CW'(imem_req_valid) - CW'(imem_rsp_valid);
      count_n     = '0;
      state_n     = (discard_n != '0) ? FS_FLUSH : FS_RUN;
    end else begin
      if (fire) begin
        if (req_stale) begin
          req_stale_n = 1'b0;
        end else begin
          pc_n = pc + WIDTH'(4);
        end
      end
      if (push) begin
        rsp_pc_n = rsp_pc + WIDTH'(4);
      end
      if (imem_rsp_valid && (discard != '0)) begin
        discard_n = discard - CW'(1);
      end
      if ((state == FS_FLUSH) && (discard_n == '0)) begin
        state_n = FS_RUN;
      end
    end

    // Every raised request already owns a FIFO slot, so responses never stall.
    raise       = (state_n == FS_RUN) && (!imem_req_valid || fire) &&
                  ((count_n + outstanding_n) < CREDITS);
    req_valid_n = raise || (imem_req_valid && !fire);
    req_addr_n  = raise ? pc_n : imem_req_addr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc             <= RESET_PC;
      rsp_pc         <= RESET_PC;
      imem_req_valid <= 1'b0;
      imem_req_addr  <= RESET_PC;
      req_stale      <= 1'b0;
      outstanding    <= '0;
      discard        <= '0;
      state          <= FS_RUN;
    end else begin
      pc             <= pc_n;
      rsp_pc         <= rsp_pc_n;
      imem_req_valid <= req_valid_n;
      imem_req_addr  <= req_addr_n;
      req_stale      <= req_stale_n;
      outstanding    <= outstanding_n;
      discard        <= discard_n;
      state          <= state_n;
    end
  end

endmodule
